// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//
// Bit-serial adder/subtractor. One full-adder cell is reused over WIDTH clock
// cycles, LSB first, to produce a WIDTH-bit result plus carry-out and signed
// overflow flags.
//
// Handshake (start/busy/done):
//   start is sampled on a rising edge only while the unit is not busy (state
//   IDLE or DONE). That edge captures a, b, mode and cin, and busy is high
//   from then on for exactly WIDTH cycles. done is a one-cycle pulse in the
//   cycle after the MSB is processed; sum/cout/ovf are valid from that cycle
//   and hold until the next completion. A start seen during DONE is accepted
//   directly, so results can stream back-to-back with no bubble. start while
//   busy is ignored.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request
//   mode   in   0 = a + b + cin, 1 = a - b - cin
//   a, b   in   WIDTH-bit operands
//   cin    in   carry-in (add) / borrow-in (subtract)
//   busy   out  operation in flight
//   done   out  one-cycle result-valid pulse
//   sum    out  WIDTH-bit result
//   cout   out  final carry; in subtract mode 1 means no borrow
//   ovf    out  two's-complement overflow
// -----------------------------------------------------------------------------
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // One extra bit so the counter can represent WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic             c_msb_in;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_bit;
  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] res_nxt;

  // Full-adder cell and control decodes.
  always_comb begin
    accept   = start && (state != RUN);
    last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));
    s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
    c_bit    = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    res_nxt  = {s_bit, res_sr[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are decodes of the state register only, so nothing from the
  // inputs reaches the outputs combinationally.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Datapath. Subtraction is a + ~b + ~cin, so b is inverted on capture and
  // the carry is seeded with cin ^ mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= mode ? ~b : b;
      carry <= cin ^ mode;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      carry  <= c_bit;
      cnt    <= cnt + CW'(1);
      // Carry out of bit WIDTH-2 is the carry into the MSB; overflow is
      // that carry disagreeing with the carry out of the MSB.
      if (cnt == CW'(WIDTH - 2)) begin
        c_msb_in <= c_bit;
      end
      if (last_bit) begin
        sum  <= res_nxt;
        cout <= c_bit;
        ovf  <= c_msb_in ^ c_bit;
      end
    end
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Parametrised bit-serial adder/subtractor. One full-adder cell is reused over WIDTH clock cycles, LSB first, to process a WIDTH-bit operand pair. Start/busy/done handshake, add/subtract mode, carry/borrow-in, carry-out and signed-overflow flags. Intended as the area-minimal arithmetic unit for datapaths that can tolerate WIDTH-cycle latency.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when not busy.
mode  input  1  0 = add (a + b + cin), 1 = subtract (a - b - cin).
a  input  WIDTH  operand A; captured on accepted start.
b  input  WIDTH  operand B; captured on accepted start.
cin  input  1  carry-in (add) / borrow-in (subtract); captured on accepted start.
busy  output  1  operation in flight.
done  output  1  one-cycle pulse; result valid.
sum  output  WIDTH  result.
cout  output  1  final carry; in subtract mode 1 = no borrow.
ovf  output  1  two's-complement overflow.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset (async, any time, including mid-operation): state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0. The in-flight operation is discarded and no done is issued.
- FSM states are IDLE, RUN and DONE.
- IDLE, or DONE, with start=1 at edge E0:
  - Capture a into shift register A.
  - Capture (mode ? ~b : b) into shift register B.
  - carry := cin ^ mode.
  - Bit counter := 0; go to RUN; busy=1 from E0.
- start while RUN: ignored; captured operands are unaffected.
- RUN, each edge:
  - s = A[0]^B[0]^carry.
  - carry := majority(A[0], B[0], carry).
  - Shift A and B right; shift s into the MSB of the result shift register.
  - Increment the counter.
  - At the edge that processes bit WIDTH-2, also record c_msb_in := the carry out of that bit, which is the carry into the MSB.
- At edge E0+WIDTH the MSB is processed. On that edge:
  - sum := full result register.
  - cout := final carry.
  - ovf := c_msb_in ^ final carry.
  - Go to DONE; busy=0, done=1.
- DONE lasts exactly one cycle, then IDLE. A start in DONE is accepted (back-to-back issue, no bubble).
- Latency: done is high in the cycle after edge E0+WIDTH, i.e. exactly WIDTH cycles after the accept edge. Throughput is one result per WIDTH+1 cycles when start is held.
- sum/cout/ovf hold the last completed result until the next completion. They are not cleared by a new start.
- Subtract: a + ~b + ~cin (mod 2^WIDTH). With cin=0 this is a - b; cin=1 subtracts an extra 1.
- The counter width is clog2(WIDTH)+1 and must not wrap before WIDTH.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. WIDTH=8, add, a=8'h3C, b=8'h45, cin=0 -> sum=8'h81, cout=0, ovf=1. done high exactly 8 cycles after the accept edge; busy high for those 8 cycles.
2. add, a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then add a=8'h0F, b=8'h10, cin=1 -> sum=8'h20, cout=0, ovf=0.
3. sub, a=8'h05, b=8'h07, cin=0 -> sum=8'hFE, cout=0 (borrow), ovf=0. Then sub a=8'h80, b=8'h01, cin=0 -> sum=8'h7F, cout=1, ovf=1.
4. Accept add 8'h12+8'h34. Pulse start with a=8'hFF, b=8'hFF at cycle 3 of RUN -> ignored; result sum=8'h46. Hold start high through DONE with new operands 8'h01+8'h01 -> accepted in the DONE cycle; second done is 9 cycles after the first; sum=8'h02.
5. Reset mid-operation: assert rst_n=0 asynchronously (between edges) during cycle 4 of RUN -> busy, done, sum, cout and ovf go 0 immediately, and no done pulse follows. After release, add 8'h7F+8'h01 -> sum=8'h80, ovf=1, cout=0.
6. Parameter sweep WIDTH=2, 16, 64: random add/sub vectors vs reference model. Check latency equals WIDTH, and cout/ovf for all-ones and sign-boundary operands.
